bounce_step_sequencer: RTL

Control sequencer for the bouncing-LED physics datapath (q8.24 position/velocity registers). It generates the periodic physics time step and splits each step into one-cycle strobes: velocity decay, position integrate, floor/ceiling collision. It also arbitrates user restart/kick requests against time steps so that no two datapath updates ever land in the same cycle. It sits between the key synchronizers and the physics register block; it holds no arithmetic itself.

---
 rtl/bounce_pkg.sv | 23 ++
 rtl/bounce_tick_gen.sv | 27 ++
 rtl/bounce_step_sequencer.sv | 104 ++++++++++
 3 files changed

// File: rtl/bounce_pkg.sv
// Shared types and constants for the bouncing-LED step sequencer and its physics datapath.
package bounce_pkg;

  typedef enum logic [2:0] {IDLE, INIT, KICK, VEL, POS, COLLIDE} bounce_state_t;

  localparam int TICK_CYCLES_DEFAULT = 1024;

  // Per-step velocity decrement in q8.24; the datapath alternates them under Delta_sel.
  localparam logic [31:0] DELTA_V_LOW  = 32'd3355;
  localparam logic [31:0] DELTA_V_HIGH = 32'd3356;

  function automatic bounce_state_t arbitrate(input logic restart_p,
                                              input logic kick_p,
                                              input logic tick_p);
    bounce_state_t s;
    if (restart_p)   s = INIT;
    else if (kick_p) s = KICK;
    else if (tick_p) s = VEL;
    else             s = IDLE;
    return s;
  endfunction

endpackage

// File: rtl/bounce_tick_gen.sv
// Physics time-base: counts 0..TICK_CYCLES-1 and pulses terminal for one cycle at the last count.
module bounce_tick_gen #(
  parameter int TICK_CYCLES = 1024
) (
  input  logic CLOCK_50,
  input  logic Reset,
  input  logic clear,
  input  logic hold,
  output logic terminal
);

  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge CLOCK_50) begin
    if (Reset || clear)
      count <= '0;
    else if (!hold)
      count <= (count == LAST) ? '0 : count + CW'(1);
  end

  // A held counter parked on the last value must not keep re-firing.
  assign terminal = (count == LAST) && !hold;

endmodule

// File: rtl/bounce_step_sequencer.sv
// Step sequencer for the bouncing-LED physics datapath: arbitrates restart/kick/tick into one-cycle strobes.
// Optional SINGLE_STEP_EN adds Pause (holds the time-base) and Step_req (manual step).
module bounce_step_sequencer
  import bounce_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEFAULT,
  parameter int STEP_CNT_W  = 16
) (
  input  logic                  CLOCK_50,
  input  logic                  Reset,
  input  logic                  Restart_req,
  input  logic                  Kick_req,
`ifdef SINGLE_STEP_EN
  input  logic                  Pause,
  input  logic                  Step_req,
`endif
  output logic                  Load_init,
  output logic                  Kick_strobe,
  output logic                  Vel_strobe,
  output logic                  Pos_strobe,
  output logic                  Collide_strobe,
  output logic                  Delta_sel,
  output logic                  Busy,
  output logic [STEP_CNT_W-1:0] Step_count,
  output logic                  Overrun
);

  bounce_state_t state, next_state;
  logic restart_pending, kick_pending, tick_pending;
  logic terminal, tick_set, hold, in_init;

`ifdef SINGLE_STEP_EN
  assign hold     = Pause;
  assign tick_set = terminal | Step_req;
`else
  assign hold     = 1'b0;
  assign tick_set = terminal;
`endif

  assign in_init = (state == INIT);

  bounce_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .clear    (in_init),
    .hold     (hold),
    .terminal (terminal)
  );

  // KICK and COLLIDE re-arbitrate on their exit edge so a queued request costs no idle cycle.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE, KICK, COLLIDE: next_state = arbitrate(restart_pending, kick_pending, tick_pending);
      INIT:                next_state = IDLE;
      VEL:                 next_state = POS;
      POS:                 next_state = COLLIDE;
      default:             next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state           <= IDLE;
      restart_pending <= 1'b0;
      kick_pending    <= 1'b0;
      tick_pending    <= 1'b0;
      Load_init       <= 1'b0;
      Kick_strobe     <= 1'b0;
      Vel_strobe      <= 1'b0;
      Pos_strobe      <= 1'b0;
      Collide_strobe  <= 1'b0;
      Busy            <= 1'b0;
      Delta_sel       <= 1'b0;
      Step_count      <= '0;
      Overrun         <= 1'b0;
    end else begin
      state           <= next_state;
      Load_init       <= (next_state == INIT);
      Kick_strobe     <= (next_state == KICK);
      Vel_strobe      <= (next_state == VEL);
      Pos_strobe      <= (next_state == POS);
      Collide_strobe  <= (next_state == COLLIDE);
      Busy            <= (next_state != IDLE);

      // A new request in the same cycle as its clear always survives.
      restart_pending <= Restart_req | (restart_pending & (next_state != INIT));
      kick_pending    <= Kick_req | (kick_pending & (next_state != KICK) & !in_init);
      tick_pending    <= tick_set | (tick_pending & (next_state != VEL) & !in_init);
      Overrun         <= (tick_set & tick_pending) | (Overrun & !in_init);

      if (in_init) begin
        Delta_sel  <= 1'b0;
        Step_count <= '0;
      end else if (state == COLLIDE) begin
        Delta_sel  <= ~Delta_sel;
        Step_count <= Step_count + STEP_CNT_W'(1);
      end
    end
  end

endmodule
